// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and constants for the RivRtos instruction fetch stage
// Revision: 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Clears the low two bits so every request address is word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : PC owner, imem req/ack fetch FSM, one-entry hold buffer, redirect
// Revision: 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [31:0] target_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_inst_q, out_inst_d;
  logic [31:0]  out_pc_q, out_pc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      kill_q        <= 1'b0;
      redirect_pc_q <= RESET_PC;
      hold_inst_q   <= NOP_INST;
      hold_pc_q     <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_inst_q    <= NOP_INST;
      out_pc_q      <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      redirect_pc_q <= redirect_pc_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc_q     <= hold_pc_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    redirect_pc_d = redirect_pc_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    out_valid_d   = out_valid_q && stall;
    out_inst_d    = out_inst_q;
    out_pc_d      = out_pc_q;

    case (state_q)
      IDLE: begin
        // A late ack from before reset is ignored here.
        state_d = REQ;
        if (pc_sel) begin
          out_valid_d = 1'b0;
          fetch_pc_d  = align_pc(target_pc);
        end
      end

      REQ: begin
        if (pc_sel) begin
          out_valid_d = 1'b0;
          if (imem_ack) begin
            kill_d     = 1'b0;
            fetch_pc_d = align_pc(target_pc);
          end else begin
            // Request cannot be withdrawn: park the target until the ack lands.
            kill_d        = 1'b1;
            redirect_pc_d = align_pc(target_pc);
          end
        end else if (imem_ack) begin
          if (kill_q) begin
            kill_d     = 1'b0;
            fetch_pc_d = redirect_pc_q;
          end else if (!out_valid_q || !stall) begin
            out_valid_d = 1'b1;
            out_inst_d  = imem_rdata;
            out_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + 32'd4;
          end else begin
            hold_inst_d = imem_rdata;
            hold_pc_d   = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + 32'd4;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        if (pc_sel) begin
          out_valid_d = 1'b0;
          fetch_pc_d  = align_pc(target_pc);
          state_d     = REQ;
        end else if (!stall) begin
          out_valid_d = 1'b1;
          out_inst_d  = hold_inst_q;
          out_pc_d    = hold_pc_q;
          state_d     = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state_q == REQ);
    imem_addr    = fetch_pc_q;
    if_valid     = out_valid_q;
    if_inst      = out_inst_q;
    if_pc        = out_pc_q;
    if_pc_plus_4 = out_pc_q + 32'd4;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed self-checking bench for fetch_unit (memory returns ~addr)
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_sel;
  logic [31:0] target_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;

  logic        auto_ack;
  logic        man_ack;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [127:0] got, exp;

  always #5 clk = ~clk;

  // Zero-wait memory when auto_ack is set, otherwise ack is driven by hand.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = ~imem_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_sel       (pc_sel),
    .target_pc    (target_pc),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .if_pc_plus_4 (if_pc_plus_4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_sel = 1'b0; target_pc = '0; stall = 1'b0;
    auto_ack = 1'b1; man_ack = 1'b0;
    step(); step();
    got = 128'({imem_req, imem_addr, if_valid});
    exp = 128'({1'b0, 32'h0, 1'b0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_ctrl: got %h exp %h", got, exp); end
    got = 128'({if_inst, if_pc, if_pc_plus_4});
    exp = 128'({32'h0000_0013, 32'h0, 32'h4});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_data: got %h exp %h", got, exp); end
    reset = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_noreq: got %b exp 0", imem_req); end
    step();
    got = 128'({imem_req, imem_addr, if_valid});
    exp = 128'({1'b1, 32'h0, 1'b0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL first_req: got %h exp %h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      step();
      got = 128'({if_valid, if_pc, if_inst, if_pc_plus_4});
      exp = 128'({1'b1, 32'(4 * i), ~(32'(4 * i)), 32'(4 * i + 4)});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL stream[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = 128'({imem_req, if_valid, if_pc, if_inst, imem_addr});
      exp = 128'({1'b0, 1'b1, 32'hC, ~32'hC, 32'h14});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, got, exp); end
    end
    stall = 1'b0;
    step();
    got = 128'({if_valid, if_pc, if_inst, imem_req, imem_addr});
    exp = 128'({1'b1, 32'h10, ~32'h10, 1'b1, 32'h14});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL stall_release: got %h exp %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      step();
      got = 128'({if_valid, if_pc, if_inst});
      exp = 128'({1'b1, 32'(32'h14 + 4 * i), ~(32'(32'h14 + 4 * i))});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL stall_after[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_redirect_outstanding();
    auto_ack = 1'b0;
    step();
    got = 128'({if_valid, imem_req, imem_addr});
    exp = 128'({1'b0, 1'b1, 32'h20});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL pend_req: got %h exp %h", got, exp); end
    pc_sel = 1'b1; target_pc = 32'h0000_0100;
    step();
    pc_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = 128'({if_valid, imem_req, imem_addr});
      exp = 128'({1'b0, 1'b1, 32'h20});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL kill_wait[%0d]: got %h exp %h", i, got, exp); end
      if (i == 0) step();
    end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    got = 128'({if_valid, imem_addr});
    exp = 128'({1'b0, 32'h100});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL kill_drop: got %h exp %h", got, exp); end
    auto_ack = 1'b1;
    step();
    got = 128'({if_valid, if_pc, if_inst});
    exp = 128'({1'b1, 32'h100, ~32'h100});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL kill_target: got %h exp %h", got, exp); end
  endtask

  task automatic test_redirect_same_cycle();
    pc_sel = 1'b1; target_pc = 32'h0000_0102;
    step();
    pc_sel = 1'b0;
    got = 128'({if_valid, imem_req, imem_addr});
    exp = 128'({1'b0, 1'b1, 32'h100});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL same_drop: got %h exp %h", got, exp); end
    step();
    got = 128'({if_valid, if_pc, if_inst, if_pc_plus_4});
    exp = 128'({1'b1, 32'h100, ~32'h100, 32'h104});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL same_target: got %h exp %h", got, exp); end
    step();
    got = 128'({if_valid, if_pc});
    exp = 128'({1'b1, 32'h104});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL same_next: got %h exp %h", got, exp); end
  endtask

  task automatic test_double_redirect();
    auto_ack = 1'b0;
    step();
    pc_sel = 1'b1; target_pc = 32'h0000_0200;
    step();
    pc_sel = 1'b0;
    step();
    got = 128'({if_valid, imem_req, imem_addr});
    exp = 128'({1'b0, 1'b1, 32'h108});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL dbl_wait: got %h exp %h", got, exp); end
    pc_sel = 1'b1; target_pc = 32'h0000_0300;
    step();
    pc_sel = 1'b0; man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    got = 128'({if_valid, imem_addr});
    exp = 128'({1'b0, 32'h300});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL dbl_addr: got %h exp %h", got, exp); end
    auto_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      got = 128'({if_valid, if_pc, if_inst});
      exp = 128'({1'b1, 32'(32'h300 + 4 * i), ~(32'(32'h300 + 4 * i))});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL dbl_stream[%0d]: got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_wrap();
    pc_sel = 1'b1; target_pc = 32'hFFFF_FFF8;
    step();
    pc_sel = 1'b0;
    got = 128'({if_valid, imem_addr});
    exp = 128'({1'b0, 32'hFFFF_FFF8});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL wrap_addr: got %h exp %h", got, exp); end
    step();
    got = 128'({if_valid, if_pc, if_pc_plus_4});
    exp = 128'({1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL wrap_m8: got %h exp %h", got, exp); end
    step();
    got = 128'({if_valid, if_pc, if_pc_plus_4, imem_addr});
    exp = 128'({1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL wrap_m4: got %h exp %h", got, exp); end
    step();
    got = 128'({if_valid, if_pc, if_inst, if_pc_plus_4});
    exp = 128'({1'b1, 32'h0, ~32'h0, 32'h4});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL wrap_zero: got %h exp %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    auto_ack = 1'b0;
    step();
    got = 128'({if_valid, imem_req, imem_addr});
    exp = 128'({1'b0, 1'b1, 32'h4});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL mid_pending: got %h exp %h", got, exp); end
    #2 reset = 1'b1;
    #1;
    got = 128'({imem_req, if_valid, imem_addr, if_pc});
    exp = 128'({1'b0, 1'b0, 32'h0, 32'h0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL mid_async: got %h exp %h", got, exp); end
    step();
    man_ack = 1'b1;
    reset = 1'b0;
    step();
    got = 128'({if_valid, imem_req, imem_addr});
    exp = 128'({1'b0, 1'b1, 32'h0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL late_ack: got %h exp %h", got, exp); end
    man_ack = 1'b0;
    step();
    n_cmp++;
    if (if_valid !== 1'b0) begin n_err++; $display("FAIL late_stale: got %b exp 0", if_valid); end
    auto_ack = 1'b1;
    step();
    got = 128'({if_valid, if_pc, if_inst});
    exp = 128'({1'b1, 32'h0, ~32'h0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL restart: got %h exp %h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_double_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage of the RivRtos core.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Delivers instruction, PC and PC+4 to decode.
- Consumes the `pc_sel`/target redirect produced by the branch controller. It is the receiving end of that interface: it flushes wrong-path work and restarts fetch at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `pc_sel`  in  1  redirect request from branch controller (taken branch or jump)
- `target_pc`  in  32  redirect address, valid when `pc_sel`=1
- `stall`  in  1  decode cannot accept the current `if_*` word this cycle
- `imem_req`  out  1  instruction memory request
- `imem_addr`  out  32  request address, word aligned
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle and completes the request
- `imem_rdata`  in  32  fetched instruction
- `if_valid`  out  1  `if_inst`/`if_pc` hold a valid instruction for decode
- `if_inst`  out  32  instruction to decode
- `if_pc`  out  32  address of `if_inst`
- `if_pc_plus_4`  out  32  `if_pc` + 4, modulo 2^32

## Operation
State machine `fetch_state_t`:
- **IDLE**: reset state. Unconditionally → REQ next cycle.
- **REQ**: `imem_req`=1 and `imem_addr`=`fetch_pc`.
  - The address is held stable until `imem_ack`. A request is never withdrawn.
  - On ack, with no kill pending, no `pc_sel`, and output slot free (`!if_valid || !stall`): load output register, `fetch_pc` += 4, stay in REQ.
  - On ack, with no kill pending, no `pc_sel`, and output slot occupied: capture the word into the hold buffer, go to HOLD.
- **HOLD**: `imem_req`=0. When `!stall`, move the hold buffer to the output register and go to REQ.

Output register:
- A valid word leaves when `if_valid && !stall`.
- If nothing replaces it that cycle, `if_valid` falls.

Redirect (`pc_sel`=1) has priority over `stall` and ack:
- `if_valid` clears next cycle; the hold buffer is discarded.
- Next request address = {`target_pc`[31:2], 2'b00}.
- In REQ with no ack this cycle: set `kill` and latch the target into `redirect_pc`. The request stays on the old address until ack. The acked data is dropped, then REQ restarts at `redirect_pc`.
- In REQ with ack the same cycle: drop the data; the next cycle requests the target.
- `pc_sel` while `kill` is already set: `redirect_pc` is overwritten with the newest target.
- In HOLD: discard the buffer, → REQ at the target.

Arithmetic:
- All PC math is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 0.

## Timing
Reset values:
- `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0
- `if_inst`=32'h0000_0013 (NOP), `if_pc`=`RESET_PC`, `if_pc_plus_4`=`RESET_PC`+4
- `kill`=0, state IDLE

Cycle-level behaviour:
- First `imem_req` is the 2nd rising edge after `reset` deasserts.
- Ack at cycle N → `if_valid`=1 with that word in cycle N+1.
- Zero-wait memory (ack in the same cycle as req): sustained 1 instruction/cycle with no bubbles while `stall`=0.
- Redirect in cycle N with no outstanding unacked request: `imem_addr`=target in cycle N+1; first target instruction valid in N+2 at the earliest.
- `reset` asserted mid-request drops everything asynchronously. A late ack arriving after reset release while in IDLE is ignored.

## Structure
- `fetch_pkg` holds:
  - `fetch_state_t` (IDLE, REQ, HOLD)
  - `NOP_INST` = 32'h0000_0013
  - `DEFAULT_RESET_PC`
- No sub-module. The single-entry hold buffer and output register stay inline (~200 lines of RTL).

## Test plan
- **Reset and stream:** reset released, memory acks in the same cycle as req, `stall`=0 → `if_pc` = 0, 4, 8, 12 on consecutive cycles after the first valid; outputs match reset values while in reset.
- **Stall:** `stall` held 3 cycles while a word is valid → `if_inst`/`if_pc` unchanged, exactly one extra word buffered (HOLD, `imem_req`=0), no loss and no duplication on release.
- **Redirect, outstanding request:** `pc_sel`=1, `target_pc`=32'h0000_0100 while a req to 0x20 is waiting (ack 2 cycles later) → 0x20 data never reaches `if_valid`; next `imem_addr`=0x100.
- **Redirect with ack in the same cycle, and misaligned target:** `pc_sel` with target 32'h0000_0102 coincident with ack → data dropped, `imem_addr`=0x100.
- **Double redirect:** two `pc_sel` pulses (targets 0x200 then 0x300) during one pending request → fetch resumes at 0x300 only.
- **Wrap and mid-request reset:**
  - PC reaches 32'hFFFF_FFFC → `if_pc_plus_4`=0 and the next `imem_addr`=0.
  - `reset` asserted while `imem_req`=1 → `imem_req` drops immediately and no stale `if_valid` appears afterwards.
